// File: rtl/quad_pkg.sv
// Shared encodings and helpers for the quadrature decoder.
package quad_pkg;

    // Step command encoding consumed by the up/down position counter
    localparam logic [1:0] UD_NONE = 2'b00;
    localparam logic [1:0] UD_UP   = 2'b01;
    localparam logic [1:0] UD_DOWN = 2'b10;

    localparam int ERR_CNT_W = 8;

    typedef enum logic {
        ST_INIT,
        ST_RUN
    } quad_state_t;

    // A leads B: 00 -> 10 -> 11 -> 01 -> 00
    function automatic logic is_fwd(input logic [1:0] prev, input logic [1:0] cur);
        case ({prev, cur})
            4'b00_10, 4'b10_11, 4'b11_01, 4'b01_00: is_fwd = 1'b1;
            default:                                is_fwd = 1'b0;
        endcase
    endfunction

    // B leads A: 00 -> 01 -> 11 -> 10 -> 00
    function automatic logic is_rev(input logic [1:0] prev, input logic [1:0] cur);
        case ({prev, cur})
            4'b00_01, 4'b01_11, 4'b11_10, 4'b10_00: is_rev = 1'b1;
            default:                                is_rev = 1'b0;
        endcase
    endfunction

endpackage

// File: rtl/quad_filter.sv
// Two-flop synchronizer followed by a persistence glitch filter for one
// encoder channel. The synchronized level is also exported so the decoder
// can seed its history while the filter is bypassed.
module quad_filter #(
    parameter int FILTER_LEN = 4
) (
    input  logic clk,
    input  logic reset,
    input  logic in,
    input  logic bypass,
    output logic sync,
    output logic filt
);

    localparam logic [3:0] CNT_LAST = 4'(FILTER_LEN - 1);

    logic [1:0] sync_q, sync_d;
    logic       filt_q, filt_d;
    logic [3:0] cnt_q,  cnt_d;

    // Shift the raw input through the metastability chain; filter tracks it
    always_comb begin
        sync_d = {sync_q[0], in};
        filt_d = filt_q;
        cnt_d  = cnt_q;
        if (bypass) begin
            filt_d = sync_q[1];
            cnt_d  = '0;
        end else if (sync_q[1] == filt_q) begin
            cnt_d  = '0;
        end else if (cnt_q == CNT_LAST) begin
            filt_d = sync_q[1];
            cnt_d  = '0;
        end else begin
            cnt_d  = cnt_q + 4'd1;
        end
    end

    // State registers, cleared asynchronously
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            sync_q <= '0;
            filt_q <= 1'b0;
            cnt_q  <= '0;
        end else begin
            sync_q <= sync_d;
            filt_q <= filt_d;
            cnt_q  <= cnt_d;
        end
    end

    assign sync = sync_q[1];
    assign filt = filt_q;

endmodule

// File: rtl/quad_decoder.sv
// x4 quadrature decoder: filtered A/B channels are compared with the previous
// sample every cycle and turned into registered one-cycle step commands.
// Double transitions are reported as errors and counted with saturation.
module quad_decoder
    import quad_pkg::*;
#(
    parameter int FILTER_LEN = 4
) (
    input  logic                 clk,
    input  logic                 reset,
    input  logic                 a_in,
    input  logic                 b_in,
    input  logic                 clr_err,
    output logic [1:0]           up_down,
    output logic                 step,
    output logic                 dir,
    output logic                 err,
    output logic [ERR_CNT_W-1:0] err_cnt
);

    // INIT covers the synchronizer depth plus one filter window
    localparam logic [4:0] INIT_LAST = 5'(FILTER_LEN + 1);

    quad_state_t          state_q,    state_d;
    logic [4:0]           init_cnt_q, init_cnt_d;
    logic [1:0]           prev_ab_q,  prev_ab_d;
    logic [1:0]           up_down_q,  up_down_d;
    logic                 step_q,     step_d;
    logic                 dir_q,      dir_d;
    logic                 err_q,      err_d;
    logic [ERR_CNT_W-1:0] err_cnt_q,  err_cnt_d;

    logic       bypass;
    logic       s_a, s_b;
    logic       filt_a, filt_b;
    logic [1:0] cur;

    assign bypass = (state_q == ST_INIT);
    assign cur    = {filt_a, filt_b};

    quad_filter #(.FILTER_LEN(FILTER_LEN)) u_filt_a (
        .clk    (clk),
        .reset  (reset),
        .in     (a_in),
        .bypass (bypass),
        .sync   (s_a),
        .filt   (filt_a)
    );

    quad_filter #(.FILTER_LEN(FILTER_LEN)) u_filt_b (
        .clk    (clk),
        .reset  (reset),
        .in     (b_in),
        .bypass (bypass),
        .sync   (s_b),
        .filt   (filt_b)
    );

    // Next state, transition decode and error counting
    always_comb begin
        state_d    = state_q;
        init_cnt_d = init_cnt_q;
        prev_ab_d  = prev_ab_q;
        up_down_d  = UD_NONE;
        step_d     = 1'b0;
        dir_d      = dir_q;
        err_d      = 1'b0;

        case (state_q)
            ST_INIT: begin
                prev_ab_d  = {s_a, s_b};
                init_cnt_d = init_cnt_q + 5'd1;
                if (init_cnt_q == INIT_LAST) begin
                    state_d    = ST_RUN;
                    init_cnt_d = '0;
                end
            end
            ST_RUN: begin
                prev_ab_d = cur;
                if (is_fwd(prev_ab_q, cur)) begin
                    up_down_d = UD_UP;
                    step_d    = 1'b1;
                    dir_d     = 1'b0;
                end else if (is_rev(prev_ab_q, cur)) begin
                    up_down_d = UD_DOWN;
                    step_d    = 1'b1;
                    dir_d     = 1'b1;
                end else if ((prev_ab_q ^ cur) == 2'b11) begin
                    err_d     = 1'b1;
                end
            end
            default: state_d = ST_INIT;
        endcase

        // Count each err pulse as it is presented; a clear wins over it
        err_cnt_d = err_cnt_q;
        if (clr_err) begin
            err_cnt_d = '0;
        end else if (err_q && (err_cnt_q != {ERR_CNT_W{1'b1}})) begin
            err_cnt_d = err_cnt_q + 1'b1;
        end
    end

    // Control and output registers, cleared asynchronously
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q    <= ST_INIT;
            init_cnt_q <= '0;
            prev_ab_q  <= '0;
            up_down_q  <= UD_NONE;
            step_q     <= 1'b0;
            dir_q      <= 1'b0;
            err_q      <= 1'b0;
            err_cnt_q  <= '0;
        end else begin
            state_q    <= state_d;
            init_cnt_q <= init_cnt_d;
            prev_ab_q  <= prev_ab_d;
            up_down_q  <= up_down_d;
            step_q     <= step_d;
            dir_q      <= dir_d;
            err_q      <= err_d;
            err_cnt_q  <= err_cnt_d;
        end
    end

    assign up_down = up_down_q;
    assign step    = step_q;
    assign dir     = dir_q;
    assign err     = err_q;
    assign err_cnt = err_cnt_q;

endmodule

// File: tb/tb_quad_decoder.sv
// Scoreboard bench for quad_decoder: expected output events are queued as
// stimulus is driven, observed events are queued as the DUT emits them, and
// each scenario task compares the two queues.
module tb_quad_decoder;

    localparam int FL = 4;

    // Event tuple: {up_down[1:0], step, dir, err}
    localparam logic [4:0] EV_UP   = 5'b01100;
    localparam logic [4:0] EV_DOWN = 5'b10110;

    localparam logic [1:0] FWD_SEQ [4] = '{2'b10, 2'b11, 2'b01, 2'b00};
    localparam logic [1:0] REV_SEQ [4] = '{2'b01, 2'b11, 2'b10, 2'b00};

    logic       clk = 1'b0;
    logic       reset;
    logic       a_in;
    logic       b_in;
    logic       clr_err;
    logic [1:0] up_down;
    logic       step;
    logic       dir;
    logic       err;
    logic [7:0] err_cnt;

    int n_chk  = 0;
    int n_pass = 0;
    int last_lat;

    logic       exp_dir;
    logic [4:0] exp_q[$];
    logic [4:0] obs_q[$];

    always #5 clk = ~clk;

    quad_decoder #(.FILTER_LEN(FL)) dut (
        .clk     (clk),
        .reset   (reset),
        .a_in    (a_in),
        .b_in    (b_in),
        .clr_err (clr_err),
        .up_down (up_down),
        .step    (step),
        .dir     (dir),
        .err     (err),
        .err_cnt (err_cnt)
    );

    function automatic logic [4:0] ev_err(input logic d);
        return {2'b00, 1'b0, d, 1'b1};
    endfunction

    // Drive AB at a falling edge, then sample for the given number of cycles,
    // recording any output activity. last_lat = first active sample (1-based).
    task automatic hold_ab(input logic [1:0] ab, input int cycles);
        a_in = ab[1];
        b_in = ab[0];
        last_lat = 0;
        for (int k = 1; k <= cycles; k++) begin
            @(posedge clk);
            @(negedge clk);
            if (step || err || (up_down != 2'b00)) begin
                obs_q.push_back({up_down, step, dir, err});
                if (last_lat == 0) last_lat = k;
            end
        end
    endtask

    task automatic test_reset();
        reset = 1'b1; a_in = 1'b0; b_in = 1'b0; clr_err = 1'b0;
        repeat (3) @(negedge clk);
        n_chk++;
        if ({up_down, step, dir, err, err_cnt} !== 13'd0)
            $display("FAIL reset_vals: got ud=%b step=%b dir=%b err=%b cnt=%0d, expected all 0",
                     up_down, step, dir, err, err_cnt);
        else n_pass++;
        reset = 1'b0;
        exp_dir = 1'b0;
        hold_ab(2'b00, 3 * FL);
        n_chk++;
        if (obs_q.size() !== 0) $display("FAIL reset_quiet: got %0d events, expected 0", obs_q.size());
        else n_pass++;
        obs_q.delete();
    endtask

    task automatic test_forward();
        logic [4:0] o, e;
        for (int i = 0; i < 4; i++) begin
            exp_q.push_back(EV_UP);
            exp_dir = 1'b0;
            hold_ab(FWD_SEQ[i], 10);
            n_chk++;
            if (last_lat !== FL + 3) $display("FAIL fwd_latency: got %0d, expected %0d", last_lat, FL + 3);
            else n_pass++;
        end
        n_chk++;
        if (obs_q.size() !== exp_q.size()) $display("FAIL fwd_count: got %0d, expected %0d", obs_q.size(), exp_q.size());
        else n_pass++;
        while (obs_q.size() > 0 && exp_q.size() > 0) begin
            o = obs_q.pop_front(); e = exp_q.pop_front(); n_chk++;
            if (o !== e) $display("FAIL fwd_event: got %b, expected %b", o, e); else n_pass++;
        end
        obs_q.delete(); exp_q.delete();
    endtask

    task automatic test_reverse();
        logic [4:0] o, e;
        for (int i = 0; i < 4; i++) begin
            exp_q.push_back(EV_DOWN);
            exp_dir = 1'b1;
            hold_ab(REV_SEQ[i], 10);
        end
        n_chk++;
        if (obs_q.size() !== exp_q.size()) $display("FAIL rev_count: got %0d, expected %0d", obs_q.size(), exp_q.size());
        else n_pass++;
        while (obs_q.size() > 0 && exp_q.size() > 0) begin
            o = obs_q.pop_front(); e = exp_q.pop_front(); n_chk++;
            if (o !== e) $display("FAIL rev_event: got %b, expected %b", o, e); else n_pass++;
        end
        obs_q.delete(); exp_q.delete();
    endtask

    task automatic test_glitch();
        logic [4:0] o, e;
        hold_ab(2'b10, FL - 1);
        hold_ab(2'b00, 15);
        n_chk++;
        if (obs_q.size() !== 0) $display("FAIL glitch_short: got %0d events, expected 0", obs_q.size());
        else n_pass++;
        obs_q.delete();
        exp_q.push_back(EV_UP);
        exp_q.push_back(EV_DOWN);
        exp_dir = 1'b1;
        hold_ab(2'b10, FL);
        hold_ab(2'b00, 16);
        n_chk++;
        if (obs_q.size() !== exp_q.size()) $display("FAIL glitch_count: got %0d, expected %0d", obs_q.size(), exp_q.size());
        else n_pass++;
        while (obs_q.size() > 0 && exp_q.size() > 0) begin
            o = obs_q.pop_front(); e = exp_q.pop_front(); n_chk++;
            if (o !== e) $display("FAIL glitch_event: got %b, expected %b", o, e); else n_pass++;
        end
        obs_q.delete(); exp_q.delete();
    endtask

    task automatic test_illegal();
        logic [4:0] o, e;
        logic       done;
        // Single double transition
        exp_q.push_back(ev_err(exp_dir));
        hold_ab(2'b11, 12);
        n_chk++;
        if (err_cnt !== 8'd1) $display("FAIL err_cnt_one: got %0d, expected 1", err_cnt); else n_pass++;
        // Clear asserted while err is high: clear wins
        exp_q.push_back(ev_err(exp_dir));
        a_in = 1'b0; b_in = 1'b0; done = 1'b0;
        for (int k = 0; k < 12; k++) begin
            @(posedge clk);
            @(negedge clk);
            if (step || err || (up_down != 2'b00)) obs_q.push_back({up_down, step, dir, err});
            if (clr_err) begin
                clr_err = 1'b0;
                done = 1'b1;
                n_chk++;
                if (err_cnt !== 8'd0) $display("FAIL clr_priority: got %0d, expected 0", err_cnt); else n_pass++;
            end else if (err && !done) begin
                clr_err = 1'b1;
            end
        end
        if (!done) begin
            n_chk++;
            $display("FAIL clr_timeout: got no err within 12 cycles, expected one");
        end
        n_chk++;
        if (err_cnt !== 8'd0) $display("FAIL clr_hold: got %0d, expected 0", err_cnt); else n_pass++;
        // 256 more errors saturate the count
        for (int i = 0; i < 256; i++) begin
            exp_q.push_back(ev_err(exp_dir));
            hold_ab((i % 2 == 0) ? 2'b11 : 2'b00, 9);
        end
        n_chk++;
        if (err_cnt !== 8'd255) $display("FAIL err_cnt_sat: got %0d, expected 255", err_cnt); else n_pass++;
        exp_q.push_back(ev_err(exp_dir));
        hold_ab(2'b11, 10);
        n_chk++;
        if (err_cnt !== 8'd255) $display("FAIL err_cnt_hold: got %0d, expected 255", err_cnt); else n_pass++;
        clr_err = 1'b1;
        @(posedge clk);
        @(negedge clk);
        clr_err = 1'b0;
        n_chk++;
        if (err_cnt !== 8'd0) $display("FAIL err_cnt_clr: got %0d, expected 0", err_cnt); else n_pass++;
        n_chk++;
        if (obs_q.size() !== exp_q.size()) $display("FAIL ill_count: got %0d, expected %0d", obs_q.size(), exp_q.size());
        else n_pass++;
        while (obs_q.size() > 0 && exp_q.size() > 0) begin
            o = obs_q.pop_front(); e = exp_q.pop_front(); n_chk++;
            if (o !== e) $display("FAIL ill_event: got %b, expected %b", o, e); else n_pass++;
        end
        obs_q.delete(); exp_q.delete();
    endtask

    task automatic test_init_hold11();
        logic [4:0] o, e;
        reset = 1'b1; a_in = 1'b1; b_in = 1'b1;
        repeat (3) @(negedge clk);
        reset = 1'b0;
        exp_dir = 1'b0;
        hold_ab(2'b11, 20);
        n_chk++;
        if (obs_q.size() !== 0) $display("FAIL init11_quiet: got %0d events, expected 0", obs_q.size());
        else n_pass++;
        obs_q.delete();
        exp_q.push_back(EV_UP);
        hold_ab(2'b01, 12);
        n_chk++;
        if (obs_q.size() !== exp_q.size()) $display("FAIL init11_count: got %0d, expected %0d", obs_q.size(), exp_q.size());
        else n_pass++;
        while (obs_q.size() > 0 && exp_q.size() > 0) begin
            o = obs_q.pop_front(); e = exp_q.pop_front(); n_chk++;
            if (o !== e) $display("FAIL init11_event: got %b, expected %b", o, e); else n_pass++;
        end
        obs_q.delete(); exp_q.delete();
    endtask

    task automatic test_mid_reset();
        logic [4:0] o, e;
        exp_q.push_back(ev_err(exp_dir));
        hold_ab(2'b10, 12);
        n_chk++;
        if (err_cnt !== 8'd1) $display("FAIL mid_err_cnt: got %0d, expected 1", err_cnt); else n_pass++;
        // 10 -> 11 is a forward step; reset after the filter updates, before the step
        a_in = 1'b1; b_in = 1'b1;
        for (int k = 1; k <= FL + 2; k++) begin
            @(posedge clk);
            @(negedge clk);
            if (step || err || (up_down != 2'b00)) obs_q.push_back({up_down, step, dir, err});
        end
        reset = 1'b1;
        #1;
        n_chk++;
        if ({up_down, step, dir, err, err_cnt} !== 13'd0)
            $display("FAIL mid_reset_vals: got ud=%b step=%b dir=%b err=%b cnt=%0d, expected all 0",
                     up_down, step, dir, err, err_cnt);
        else n_pass++;
        n_chk++;
        if (obs_q.size() !== exp_q.size()) $display("FAIL mid_count: got %0d, expected %0d", obs_q.size(), exp_q.size());
        else n_pass++;
        while (obs_q.size() > 0 && exp_q.size() > 0) begin
            o = obs_q.pop_front(); e = exp_q.pop_front(); n_chk++;
            if (o !== e) $display("FAIL mid_event: got %b, expected %b", o, e); else n_pass++;
        end
        obs_q.delete(); exp_q.delete();
        repeat (3) @(negedge clk);
        reset = 1'b0;
        exp_dir = 1'b0;
        hold_ab(2'b11, 20);
        n_chk++;
        if (obs_q.size() !== 0) $display("FAIL mid_after: got %0d events, expected 0", obs_q.size());
        else n_pass++;
        obs_q.delete();
    endtask

    // An edge captured on the FL-th clock after reset release is absorbed by
    // INIT; one captured a clock later must produce a step.
    task automatic test_init_length();
        logic [4:0] o, e;
        for (int run = 0; run < 2; run++) begin
            reset = 1'b1; a_in = 1'b0; b_in = 1'b0;
            repeat (3) @(negedge clk);
            reset = 1'b0;
            exp_dir = 1'b0;
            repeat (FL + run - 1) @(negedge clk);
            if (run == 1) exp_q.push_back(EV_UP);
            hold_ab(2'b10, 20);
            n_chk++;
            if (obs_q.size() !== exp_q.size())
                $display("FAIL init_len_count: run %0d got %0d, expected %0d", run, obs_q.size(), exp_q.size());
            else n_pass++;
            while (obs_q.size() > 0 && exp_q.size() > 0) begin
                o = obs_q.pop_front(); e = exp_q.pop_front(); n_chk++;
                if (o !== e) $display("FAIL init_len_event: got %b, expected %b", o, e); else n_pass++;
            end
            obs_q.delete(); exp_q.delete();
        end
    endtask

    initial begin
        test_reset();
        test_forward();
        test_reverse();
        test_glitch();
        test_illegal();
        test_init_hold11();
        test_mid_reset();
        test_init_length();
        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

    initial begin
        #500000;
        $display("FAIL watchdog: got no completion by 500000, expected completion");
        $fatal(1, "watchdog expired");
    end

endmodule
